// File: rtl/star_arb_pkg.sv
// Shared types and helpers for the star-token AXI-Stream arbiter node.
package star_arb_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;

    // Output mux source: upstream chain or local stream.
    typedef enum logic {
        SEL_PRV = 1'b0,
        SEL_SRC = 1'b1
    } sel_e;

    // A capture in the same cycle as a release keeps the token.
    function automatic logic star_next(input logic has_star,
                                       input logic take_star,
                                       input logic release_star);
        logic nxt;
        nxt = has_star;
        if (release_star) nxt = 1'b0;
        if (take_star)    nxt = 1'b1;
        return nxt;
    endfunction

endpackage : star_arb_pkg

// File: rtl/star_arb.sv
// One node of a token-passing AXI-Stream packet arbiter chain: merges the local
// src stream into the upstream prv stream while holding the circulating star.
module star_arb
    import star_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = DEFAULT_DATA_WIDTH,
    parameter int          RESET_TYPE      = 1,
    parameter bit          START_WITH_STAR = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  take_star,
    output logic                  give_star,
    input  logic [DATA_WIDTH-1:0] src_TDATA,
    input  logic                  src_TVALID,
    output logic                  src_TREADY,
    input  logic                  src_TLAST,
    input  logic [DATA_WIDTH-1:0] prv_TDATA,
    input  logic                  prv_TVALID,
    output logic                  prv_TREADY,
    input  logic                  prv_TLAST,
    output logic [DATA_WIDTH-1:0] res_TDATA,
    output logic                  res_TVALID,
    input  logic                  res_TREADY,
    output logic                  res_TLAST
);

    logic has_star_q, has_star_d;
    logic give_star_q, give_star_d;
    logic src_lock_q, src_lock_d;
    logic prv_busy_q, prv_busy_d;

    sel_e sel_c;
    logic src_acc_c;
    logic prv_acc_c;
    logic release_c;

    // Reset style is fixed; the legacy parameter is only accepted.
    logic unused_reset_type_c;
    assign unused_reset_type_c = (RESET_TYPE != 0);

    // A locked src packet owns the output even while it stalls.
    always_comb begin
        sel_c = SEL_PRV;
        if (src_lock_q || (has_star_q && src_TVALID && !prv_busy_q)) begin
            sel_c = SEL_SRC;
        end
    end

    always_comb begin
        res_TDATA  = prv_TDATA;
        res_TLAST  = prv_TLAST;
        res_TVALID = 1'b0;
        src_TREADY = 1'b0;
        prv_TREADY = 1'b0;
        if (sel_c == SEL_SRC) begin
            res_TDATA = src_TDATA;
            res_TLAST = src_TLAST;
        end
        if (rst) begin
            res_TVALID = (sel_c == SEL_SRC) ? src_TVALID : prv_TVALID;
            src_TREADY = (sel_c == SEL_SRC) && res_TREADY;
            prv_TREADY = (sel_c == SEL_PRV) && res_TREADY;
        end
    end

    assign src_acc_c = src_TVALID && src_TREADY;
    assign prv_acc_c = prv_TVALID && prv_TREADY;

    // Release after the TLAST beat, or immediately when holding with nothing to send.
    assign release_c = (src_acc_c && src_TLAST)
                     || (has_star_q && !src_lock_q && !src_TVALID && !prv_busy_q);

    always_comb begin
        has_star_d  = has_star_q;
        give_star_d = 1'b0;
        src_lock_d  = src_lock_q;
        prv_busy_d  = prv_busy_q;

        if (src_acc_c) src_lock_d = !src_TLAST;
        if (prv_acc_c) prv_busy_d = !prv_TLAST;

        give_star_d = release_c;
        has_star_d  = star_next(has_star_q, take_star, release_c);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            has_star_q  <= START_WITH_STAR;
            give_star_q <= 1'b0;
            src_lock_q  <= 1'b0;
            prv_busy_q  <= 1'b0;
        end else begin
            has_star_q  <= has_star_d;
            give_star_q <= give_star_d;
            src_lock_q  <= src_lock_d;
            prv_busy_q  <= prv_busy_d;
        end
    end

    assign give_star = give_star_q;

endmodule : star_arb

// File: tb/tb_star_arb.sv
// Four-node ring bench: node0 starts with the star, node3 res feeds the sink.
module tb_star_arb;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]         give, take;
    logic [N-1:0][DW-1:0] src_d, prv_d, res_d;
    logic [N-1:0]         src_v, src_r, src_l;
    logic [N-1:0]         prv_v, prv_r, prv_l;
    logic [N-1:0]         res_v, res_r, res_l;
    logic                 sink_ready;

    assign take  = {give[N-2:0], give[N-1]};
    assign prv_d = {res_d[N-2:0], DW'(0)};
    assign prv_v = {res_v[N-2:0], 1'b0};
    assign prv_l = {res_l[N-2:0], 1'b0};
    assign res_r = {sink_ready, prv_r[N-1:1]};

    for (genvar i = 0; i < N; i++) begin : g_node
        star_arb #(
            .DATA_WIDTH     (DW),
            .RESET_TYPE     (1),
            .START_WITH_STAR(i == 0)
        ) u_node (
            .clk       (clk),
            .rst       (rst),
            .take_star (take[i]),
            .give_star (give[i]),
            .src_TDATA (src_d[i]),
            .src_TVALID(src_v[i]),
            .src_TREADY(src_r[i]),
            .src_TLAST (src_l[i]),
            .prv_TDATA (prv_d[i]),
            .prv_TVALID(prv_v[i]),
            .prv_TREADY(prv_r[i]),
            .prv_TLAST (prv_l[i]),
            .res_TDATA (res_d[i]),
            .res_TVALID(res_v[i]),
            .res_TREADY(res_r[i]),
            .res_TLAST (res_l[i])
        );
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        src_d      = '0;
        src_v      = '0;
        src_l      = '0;
        sink_ready = 1'b1;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic drive_src(input int n, input logic v, input logic [DW-1:0] d, input logic l);
        src_v[n] = v;
        src_d[n] = d;
        src_l[n] = l;
    endtask

    logic [N-1:0] exp_give;

    initial begin
        // Reset holds every handshake output low even with traffic offered.
        rst        = 1'b0;
        sink_ready = 1'b1;
        src_d      = '0;
        src_l      = '0;
        src_v      = '1;
        settle();
        chk("rst_src_ready", 32'(src_r), 32'h0);
        chk("rst_prv_ready", 32'(prv_r), 32'h0);
        chk("rst_res_valid", 32'(res_v), 32'h0);
        chk("rst_give",      32'(give),  32'h0);

        // Idle ring: each node holds one cycle then passes, two cycles per hop.
        do_reset();
        settle();
        chk("idle_give0", 32'(give), 32'h0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_give = (k % 2 == 1) ? N'(1 << (((k - 1) / 2) % N)) : '0;
            chk($sformatf("idle_give_k%0d", k), 32'(give), 32'(exp_give));
            chk($sformatf("idle_valid_k%0d", k), 32'(res_v[N-1]), 32'h0);
        end

        // Node0 three-beat packet.
        do_reset();
        drive_src(0, 1'b1, 8'h00, 1'b0);
        settle();
        chk("pkt_b0_data",  32'(res_d[N-1]), 32'h00);
        chk("pkt_b0_valid", 32'(res_v[N-1]), 32'h1);
        chk("pkt_b0_ready", 32'(src_r[0]),   32'h1);
        tick();
        drive_src(0, 1'b1, 8'h04, 1'b0);
        settle();
        chk("pkt_b1_data", 32'(res_d[N-1]), 32'h04);
        chk("pkt_b1_give", 32'(give),       32'h0);
        tick();
        drive_src(0, 1'b1, 8'h08, 1'b1);
        settle();
        chk("pkt_b2_data", 32'(res_d[N-1]), 32'h08);
        chk("pkt_b2_last", 32'(res_l[N-1]), 32'h1);
        chk("pkt_b2_give", 32'(give),       32'h0);
        tick();
        drive_src(0, 1'b0, 8'h00, 1'b0);
        settle();
        chk("pkt_end_give",  32'(give),       32'h1);
        chk("pkt_end_valid", 32'(res_v[N-1]), 32'h0);

        // Node1 waits for the star while node0 sends.
        do_reset();
        drive_src(1, 1'b1, 8'h01, 1'b1);
        drive_src(0, 1'b1, 8'h00, 1'b0);
        settle();
        chk("wait_b0_r1",   32'(src_r[1]),   32'h0);
        chk("wait_b0_data", 32'(res_d[N-1]), 32'h00);
        tick();
        drive_src(0, 1'b1, 8'h04, 1'b0);
        settle();
        chk("wait_b1_r1", 32'(src_r[1]), 32'h0);
        tick();
        drive_src(0, 1'b1, 8'h08, 1'b1);
        settle();
        chk("wait_b2_r1", 32'(src_r[1]), 32'h0);
        tick();
        drive_src(0, 1'b0, 8'h00, 1'b0);
        settle();
        chk("wait_hop_give", 32'(give),     32'h1);
        chk("wait_hop_r1",   32'(src_r[1]), 32'h0);
        tick();
        settle();
        chk("wait_n1_r1",    32'(src_r[1]),   32'h1);
        chk("wait_n1_data",  32'(res_d[N-1]), 32'h01);
        chk("wait_n1_valid", 32'(res_v[N-1]), 32'h1);
        chk("wait_n1_last",  32'(res_l[N-1]), 32'h1);
        tick();
        drive_src(1, 1'b0, 8'h00, 1'b0);
        settle();
        chk("wait_n1_give", 32'(give), 32'h2);

        // Backpressure at the holder for five cycles.
        do_reset();
        sink_ready = 1'b0;
        drive_src(0, 1'b1, 8'hA5, 1'b1);
        for (int k = 0; k < 5; k++) begin
            settle();
            chk($sformatf("bp_ready_k%0d", k), 32'(src_r[0]),   32'h0);
            chk($sformatf("bp_give_k%0d", k),  32'(give),       32'h0);
            chk($sformatf("bp_data_k%0d", k),  32'(res_d[N-1]), 32'hA5);
            chk($sformatf("bp_valid_k%0d", k), 32'(res_v[N-1]), 32'h1);
            tick();
        end
        sink_ready = 1'b1;
        settle();
        chk("bp_go_ready", 32'(src_r[0]), 32'h1);
        tick();
        drive_src(0, 1'b0, 8'h00, 1'b0);
        settle();
        chk("bp_go_give", 32'(give), 32'h1);

        // Holder stalls mid-packet: output stays on src, star stays put.
        do_reset();
        drive_src(0, 1'b1, 8'h10, 1'b0);
        tick();
        drive_src(0, 1'b0, 8'h00, 1'b0);
        for (int k = 0; k < 3; k++) begin
            settle();
            chk($sformatf("gap_valid_k%0d", k), 32'(res_v[N-1]), 32'h0);
            chk($sformatf("gap_prvr_k%0d", k),  32'(prv_r[0]),   32'h0);
            chk($sformatf("gap_give_k%0d", k),  32'(give),       32'h0);
            tick();
        end
        drive_src(0, 1'b1, 8'h11, 1'b1);
        settle();
        chk("gap_last_data", 32'(res_d[N-1]), 32'h11);
        chk("gap_last_last", 32'(res_l[N-1]), 32'h1);
        chk("gap_last_give", 32'(give),       32'h0);
        tick();
        drive_src(0, 1'b0, 8'h00, 1'b0);
        settle();
        chk("gap_end_give", 32'(give), 32'h1);

        // Reset asserted mid-packet abandons it and returns the star to node0.
        do_reset();
        drive_src(0, 1'b1, 8'h20, 1'b0);
        tick();
        rst = 1'b0;
        settle();
        chk("mrst_src_ready", 32'(src_r), 32'h0);
        chk("mrst_prv_ready", 32'(prv_r), 32'h0);
        chk("mrst_res_valid", 32'(res_v), 32'h0);
        tick();
        drive_src(0, 1'b0, 8'h00, 1'b0);
        rst = 1'b1;
        settle();
        chk("mrst_rel_give", 32'(give), 32'h0);
        tick();
        settle();
        chk("mrst_pass_give", 32'(give), 32'h1);
        tick();
        settle();
        chk("mrst_pass_idle", 32'(give), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_star_arb
